// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder: FSM state encoding,
// the NOP word returned for out-of-range fetches, and the default latency.
package imem_responder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_RESP  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int DEFAULT_LATENCY = 2;

  // Latency counter is wide enough for the full 0..15 range.
  localparam int CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Word array for the instruction memory: one synchronous write port and one
// registered read port. No reset, so it maps onto block RAM. A read and a
// write to the same word on the same edge return the old word.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Write and registered read share one edge; the nonblocking read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/imem_responder.sv
// Responder side of the fetch-stage instruction-memory handshake.
// Accepts a request in IDLE, waits LATENCY edges (abortable by dropping
// enable), strobes ready for one cycle with the word, then drains until the
// requester releases enable. A side load port writes the array at any time.
// Optional: define IMEM_RANGE_CHECK_EN to flag out-of-range addresses with
// mem_rd_error and return a NOP instead of wrapping.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_enable,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_rd_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_RANGE_CHECK_EN
  output logic              mem_rd_error,
`endif
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              dvalid_q;   // a word has been read since reset
  logic              oor_q;      // last response was out of range
  logic              rd_fire;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oor;
  logic              ld_oor;
  logic [DATA_W-1:0] arr_data;

  // Array read address: the live address on a zero-latency acceptance,
  // otherwise the one captured at acceptance.
  assign rd_addr = (state_q == ST_IDLE) ? mem_rd_addr : addr_q;

`ifdef IMEM_RANGE_CHECK_EN
  assign rd_oor = |rd_addr[ADDR_W-1:DEPTH_LOG2+2];
  assign ld_oor = |load_addr[ADDR_W-1:DEPTH_LOG2+2];
`else
  assign rd_oor = 1'b0;
  assign ld_oor = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dropping enable during WAIT is a flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (mem_rd_enable) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!mem_rd_enable)      state_d = ST_IDLE;
        else if (cnt_q == 4'd1)  state_d = ST_RESP;
      end
      ST_RESP:  state_d = mem_rd_enable ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!mem_rd_enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and the array read strobe, decoded from the current state.
  always_comb begin
    mem_rd_ready = (state_q == ST_RESP);
    busy         = (state_q == ST_WAIT) || (state_q == ST_RESP);
    rd_fire      = 1'b0;
    if (state_q == ST_IDLE && mem_rd_enable && LATENCY == 0)   rd_fire = 1'b1;
    if (state_q == ST_WAIT && mem_rd_enable && cnt_q == 4'd1)  rd_fire = 1'b1;
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else if (state_q == ST_IDLE && mem_rd_enable) begin
      cnt_q  <= LAT_CNT;
      addr_q <= mem_rd_addr;
    end else if (state_q == ST_WAIT) begin
      cnt_q  <= mem_rd_enable ? cnt_q - CNT_W'(1) : '0;
    end
  end

  // Response bookkeeping: the array output has no reset, so gate it to zero
  // until the first read, and remember whether the response is a NOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvalid_q <= 1'b0;
      oor_q    <= 1'b0;
    end else if (rd_fire) begin
      dvalid_q <= 1'b1;
      oor_q    <= rd_oor;
    end
  end

  imem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .wr_en   (load_en && !ld_oor),
    .wr_idx  (load_addr[DEPTH_LOG2+1:2]),
    .wr_data (load_data),
    .rd_en   (rd_fire && !rd_oor),
    .rd_idx  (rd_addr[DEPTH_LOG2+1:2]),
    .rd_data (arr_data)
  );

  assign mem_rd_data = !dvalid_q ? '0 : (oor_q ? DATA_W'(NOP_WORD) : arr_data);

`ifdef IMEM_RANGE_CHECK_EN
  assign mem_rd_error = mem_rd_ready && oor_q;
`endif

  // Byte-offset and (in the wrapping build) upper address bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_rd_addr, load_addr, addr_q};

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-memory read handshake that the fetch stage initiates: `mem_rd_addr`, `mem_rd_enable`, `mem_rd_data` and `mem_rd_ready`.
- Holds a word array with a programmable response latency, and a side load port for preloading the program.
- Sits between the fetch stage and the testbench/boot loader. It is the simulation and FPGA instruction memory for the core.

Parameters:
- ADDR_W, 32, width of `mem_rd_addr` and `load_addr` (byte addresses).
- DATA_W, 32, width of instruction words.
- DEPTH_LOG2, 10, log2 of the number of words (1024 words).
- LATENCY, 2, cycles from request acceptance to `mem_rd_ready`; legal range 0..15.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- mem_rd_addr  in  ADDR_W  byte address of the request.
- mem_rd_enable  in  1  request valid; held high by the requester until it sees ready.
- mem_rd_data  out  DATA_W  returned instruction; valid only while `mem_rd_ready` is 1.
- mem_rd_ready  out  1  one-cycle response strobe.
- load_en  in  1  synchronous word write into the array.
- load_addr  in  ADDR_W  byte address of the load.
- load_data  in  DATA_W  word to write.
- busy  out  1  high in WAIT or RESP.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; `mem_rd_ready` = 0; `mem_rd_data` = 0; `busy` = 0; latency counter = 0; captured address = 0. Array contents are not cleared.
- Word index = addr[DEPTH_LOG2+1:2]. Bits [1:0] are ignored; the requester reports misalignment itself.
- Upper address bits are ignored, so addresses wrap modulo depth (unless IMEM_RANGE_CHECK_EN is defined).
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE:
  - Enable = 1 at an edge: capture the address and load the counter with LATENCY.
  - Go to RESP if LATENCY = 0, otherwise to WAIT.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 1, read the array into the data register and go to RESP.
- Abort: enable = 0 while in WAIT returns to IDLE on the next edge; no ready is produced. This is the flush case.
- RESP:
  - `mem_rd_ready` = 1 for exactly one cycle, with data.
  - Next edge: go to DRAIN if enable = 1, else IDLE.
  - `mem_rd_data` holds its value after RESP until the next response.
- DRAIN: waits for enable = 0, then goes to IDLE. A requester that never drops enable gets no second response.
- Latency: with acceptance at edge k, ready is high in the cycle after edge k+LATENCY.
  - LATENCY = 0 gives ready in the cycle after acceptance.
- `mem_rd_addr` changes after acceptance are ignored until the next IDLE acceptance.
- Load port:
  - A write occurs at every edge with `load_en` = 1, in any state.
  - Read-before-write: a read at the same edge as a load to the same word returns the old word.
- Reset asserted mid-WAIT or mid-RESP returns to IDLE immediately; `mem_rd_ready` drops asynchronously.

Optional Feature:
- Macro: IMEM_RANGE_CHECK_EN.
- Defined:
  - Any request address at or above 4·2^DEPTH_LOG2 completes normally after LATENCY.
  - Returns `mem_rd_data` = 32'h0000_0013 (NOP).
  - Asserts an extra output `mem_rd_error` (1 bit) together with ready.
  - `mem_rd_error` resets to 0.
  - Out-of-range loads are dropped.
- Undefined: no `mem_rd_error` port; addresses wrap modulo depth.

Decomposition:
- Shared package/params file holds:
  - state encoding localparams (IDLE = 0, WAIT = 1, RESP = 2, DRAIN = 3);
  - NOP constant 32'h0000_0013;
  - default latency constant.
- One sub-module, imem_array: single write port, registered read port, no reset. It is instantiated once inside imem_responder.

Test Plan:
- Reset/idle: hold reset = 0 for 3 cycles with enable = 1 → ready = 0, data = 0, busy = 0; release → first response after exactly LATENCY+1 cycles.
- Basic read: load word 0x4 = 32'hDEAD_BEEF; request addr 0x4 with LATENCY = 2 → ready high exactly once, 3 cycles after acceptance, data DEAD_BEEF.
- Back-to-back fetch pattern: enable toggles high/low for addrs 0x0, 0x4, 0x8 holding A, B, C → responses A, B, C in order; one ready per request.
- Abort: request 0x10, drop enable after 1 cycle (LATENCY = 4) → no ready. Next request 0x14 returns the 0x14 word with full latency.
- Stuck enable / collision: enable held high for 10 cycles → exactly one ready. A load to the same word at the read edge → old data returned; a later read returns the new data.
- Range check (IMEM_RANGE_CHECK_EN, DEPTH_LOG2 = 10): request 0x1000 → ready with data 0x0000_0013 and mem_rd_error = 1. Without the macro, 0x1000 returns the word at 0x0.
